// File: rtl/lsq_dcache.sv
// lsq_dcache: blocking, direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hit/miss counters are built only when LSQ_DCACHE_PERF_EN is defined.
module lsq_dcache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] dcache_addr,
  input  logic [3:0]  dcache_rmask,
  input  logic [3:0]  dcache_wmask,
  input  logic [31:0] dcache_wdata,
  output logic [31:0] dcache_rdata,
  output logic        dcache_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] perf_load_hit,
  output logic [31:0] perf_load_miss
);

  localparam int WB    = $clog2(LINE_WORDS);
  localparam int IB    = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 2 - WB - IB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_RESP,
    S_WRITE_REQ,
    S_WDONE
  } state_t;

  state_t              state_q;
  logic                drop_q;
  logic [WB-1:0]       cnt_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

  logic [31:2]         addr_q;
  logic                is_load_q;
  logic [3:0]          wmask_q;
  logic [31:0]         wdata_q;

  logic [WB-1:0]       word_sel;
  logic [IB-1:0]       set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [31:0]         sel_word;
  logic                hit;
  logic                req_valid;
  logic                accept;
  logic                going_idle;
  logic                resp_raw;
  logic                unused_addr_lsb;

  // Byte-lane merge of store data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr_lsb = ^dcache_addr[1:0];

  assign word_sel  = addr_q[2 +: WB];
  assign set_idx   = addr_q[2+WB +: IB];
  assign req_tag   = addr_q[31 -: TAG_W];
  assign sel_word  = data_q[set_idx][word_sel];
  assign hit       = valid_q[set_idx] && (tag_q[set_idx] == req_tag);
  assign req_valid = (|dcache_rmask) || (|dcache_wmask);
  assign accept    = (state_q == S_IDLE) && req_valid && !flush;

  assign going_idle = (state_q == S_LOOKUP && is_load_q && hit) ||
                      (state_q == S_RESP) || (state_q == S_WDONE);

  // Control: state, drop flag, beat counter, valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      if (going_idle) drop_q <= 1'b0;
      else if (state_q != S_IDLE && flush) drop_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (!is_load_q) state_q <= S_WRITE_REQ;
          else if (hit)   state_q <= S_IDLE;
          else            state_q <= S_REFILL_REQ;
        end
        S_REFILL_REQ: begin
          if (mem_ready) begin
            state_q <= S_REFILL_DATA;
            cnt_q   <= '0;
          end
        end
        S_REFILL_DATA: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_q + WB'(1);
            if (&cnt_q) begin
              valid_q[set_idx] <= 1'b1;
              state_q          <= S_RESP;
            end
          end
        end
        S_WRITE_REQ: begin
          if (mem_ready) state_q <= S_WDONE;
        end
        S_RESP, S_WDONE: state_q <= S_IDLE;
        default:         state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: request latch, tag and data arrays (not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q    <= dcache_addr[31:2];
      is_load_q <= |dcache_rmask;
      wmask_q   <= dcache_wmask;
      wdata_q   <= dcache_wdata;
    end
    if (state_q == S_LOOKUP && !is_load_q && hit) begin
      data_q[set_idx][word_sel] <= merge_bytes(sel_word, wdata_q, wmask_q);
    end
    if (state_q == S_REFILL_DATA && mem_rvalid) begin
      data_q[set_idx][cnt_q] <= mem_rdata;
      if (&cnt_q) tag_q[set_idx] <= req_tag;
    end
  end

  // Outputs decode from state; a pending drop (or a live flush) masks the response.
  always_comb begin
    resp_raw     = (state_q == S_LOOKUP && is_load_q && hit) ||
                   (state_q == S_RESP) || (state_q == S_WDONE);
    dcache_resp  = resp_raw && !drop_q && !flush;
    dcache_rdata = (dcache_resp && is_load_q) ? sel_word : '0;
    mem_read     = (state_q == S_REFILL_REQ);
    mem_write    = (state_q == S_WRITE_REQ);
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    if (state_q == S_REFILL_REQ) begin
      mem_addr = {addr_q[31:2+WB], {(2+WB){1'b0}}};
    end
    if (state_q == S_WRITE_REQ) begin
      mem_addr  = {addr_q, 2'b00};
      mem_wdata = wdata_q;
      mem_wmask = wmask_q;
    end
  end

`ifdef LSQ_DCACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP && is_load_q) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_load_hit  = hit_cnt_q;
  assign perf_load_miss = miss_cnt_q;
`else
  assign perf_load_hit  = '0;
  assign perf_load_miss = '0;
`endif

endmodule

// File: tb/tb_lsq_dcache.sv
// Directed bench for lsq_dcache: a set/tag/line model plus a backing-memory array
// predict every cycle's outputs; literal checks pin the model on the key scenarios.
module tb_lsq_dcache;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic [3:0]  dcache_rmask, dcache_wmask;
  logic        dcache_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ready, mem_rvalid;
  logic [3:0]  mem_wmask;
  logic [31:0] perf_load_hit, perf_load_miss;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsq_dcache dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dcache_addr(dcache_addr), .dcache_rmask(dcache_rmask), .dcache_wmask(dcache_wmask),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .perf_load_hit(perf_load_hit), .perf_load_miss(perf_load_miss)
  );

  // Model: 16 sets x 4 words, tag = addr[31:8]; backing memory keyed by word address
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_line  [16][4];
  logic [31:0] bmem    [logic [31:0]];
  int          m_hits, m_misses;

  logic        e_resp, e_mrd, e_mwr;
  logic [31:0] e_rdata, e_maddr, e_mwdata;
  logic [3:0]  e_mwmask;
  bit          chk_en = 1'b0;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) & 32'hF);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h3);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[set_of(a)] && (m_tag[set_of(a)] == a[31:8]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic idle_exp();
    e_resp = 0; e_rdata = 0; e_mrd = 0; e_mwr = 0;
    e_maddr = 0; e_mwdata = 0; e_mwmask = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle_exp();
  endtask

  // Per-cycle compare of all handshake outputs against the expectation set this cycle
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      n_vec++;
      if (dcache_resp !== e_resp || dcache_rdata !== e_rdata || mem_read !== e_mrd ||
          mem_write !== e_mwr || mem_addr !== e_maddr || mem_wdata !== e_mwdata ||
          mem_wmask !== e_mwmask) begin
        n_bad++;
        $display("FAIL cycle@%0t: got resp=%b rdata=%h rd=%b wr=%b addr=%h wd=%h wm=%h; want resp=%b rdata=%h rd=%b wr=%b addr=%h wd=%h wm=%h",
                 $time, dcache_resp, dcache_rdata, mem_read, mem_write, mem_addr, mem_wdata,
                 mem_wmask, e_resp, e_rdata, e_mrd, e_mwr, e_maddr, e_mwdata, e_mwmask);
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input int flush_beat, input int rst_beat,
                         output bit was_hit, output logic [31:0] got,
                         output logic [31:0] rd_addr);
    int          s, w;
    logic [31:0] base;
    bit          h, reset_hit;
    s = set_of(a); w = word_of(a); base = a & ~32'hF; h = m_hit(a);
    was_hit = h; got = 0; rd_addr = 0; reset_hit = 0;
    tick(); dcache_addr = a; dcache_rmask = 4'hF;
    tick();
    if (h) begin
      m_hits++;
      e_resp = 1; e_rdata = m_line[s][w];
      got = dcache_rdata;
      tick(); dcache_rmask = 0;
      return;
    end
    m_misses++;
    tick(); e_mrd = 1; e_maddr = base; rd_addr = mem_addr; mem_ready = 1;
    tick(); mem_ready = 0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) tick();
      if (b == rst_beat) begin
        rst = 1; mem_rvalid = 0; dcache_rmask = 0;
        model_reset();
        reset_hit = 1;
        break;
      end
      mem_rvalid = 1; mem_rdata = mem_rd(base + 32'(4 * b));
      if (b == flush_beat) flush = 1;
      tick(); mem_rvalid = 0; mem_rdata = 0; flush = 0;
    end
    if (reset_hit) begin
      tick(); tick(); rst = 0;
      return;
    end
    m_valid[s] = 1; m_tag[s] = a[31:8];
    for (int b = 0; b < 4; b++) m_line[s][b] = mem_rd(base + 32'(4 * b));
    e_resp  = (flush_beat < 0);
    e_rdata = (flush_beat < 0) ? m_line[s][w] : 32'h0;
    got = dcache_rdata;
    tick(); dcache_rmask = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd,
                          output bit was_hit);
    logic [31:0] wa;
    bit          h;
    wa = a & ~32'h3; h = m_hit(a); was_hit = h;
    tick(); dcache_addr = a; dcache_wmask = wm; dcache_wdata = wd;
    tick();
    for (int c = 0; c < 2; c++) begin
      tick(); e_mwr = 1; e_maddr = wa; e_mwdata = wd; e_mwmask = wm;
      if (c == 1) mem_ready = 1;
    end
    bmem[wa] = merge(mem_rd(wa), wd, wm);
    if (h) m_line[set_of(a)][word_of(a)] = merge(m_line[set_of(a)][word_of(a)], wd, wm);
    tick(); mem_ready = 0; e_resp = 1;
    tick(); dcache_wmask = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    logic [31:0] got, ra, ph0, pm0;
    rst = 1; flush = 0; dcache_addr = 0; dcache_rmask = 0; dcache_wmask = 0;
    dcache_wdata = 0; mem_ready = 0; mem_rdata = 0; mem_rvalid = 0;
    model_reset(); idle_exp();
    bmem[32'h1000] = 32'h11; bmem[32'h1004] = 32'h22;
    bmem[32'h1008] = 32'h33; bmem[32'h100C] = 32'h44;

    tick(); chk_en = 1;
    #1;
    chk("rst_rdata", dcache_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_flags", {28'h0, dcache_resp, mem_read, mem_write, 1'b0}, 32'h0);
    chk("rst_perf", perf_load_hit | perf_load_miss, 32'h0);
    tick(); rst = 0;

    do_load(32'h1004, -1, -1, h, got, ra);
    chk("cold_hit", 32'(h), 32'h0);
    chk("cold_rd_addr", ra, 32'h1000);
    chk("cold_rdata", got, 32'h22);
    do_load(32'h1008, -1, -1, h, got, ra);
    chk("warm_hit", 32'(h), 32'h1);
    chk("warm_rdata", got, 32'h33);

    do_store(32'h1004, 4'b0011, 32'hAAAA_BBBB, h);
    chk("st_hit", 32'(h), 32'h1);
    do_load(32'h1004, -1, -1, h, got, ra);
    chk("st_merge_rdata", got, 32'h0000_BBBB);

    do_store(32'h2000, 4'b1111, 32'h5, h);
    chk("st_miss_hit", 32'(h), 32'h0);
    do_load(32'h2000, -1, -1, h, got, ra);
    chk("st_noalloc_hit", 32'(h), 32'h0);
    chk("st_noalloc_addr", ra, 32'h2000);
    chk("st_noalloc_rdata", got, 32'h5);

    ph0 = perf_load_hit; pm0 = perf_load_miss;
    do_load(32'h1000, -1, -1, h, got, ra);
    chk("evict1_hit", 32'(h), 32'h0);
    do_load(32'h1100, -1, -1, h, got, ra);
    chk("evict2_hit", 32'(h), 32'h0);
    chk("evict2_rdata", got, 32'h5A5A_1100);
    do_load(32'h1000, -1, -1, h, got, ra);
    chk("evict3_hit", 32'(h), 32'h0);
    chk("evict3_rdata", got, 32'h11);
`ifdef LSQ_DCACHE_PERF_EN
    chk("evict_perf_hit", perf_load_hit - ph0, 32'd0);
    chk("evict_perf_miss", perf_load_miss - pm0, 32'd3);
`else
    chk("evict_perf_hit", perf_load_hit | ph0, 32'd0);
    chk("evict_perf_miss", perf_load_miss | pm0, 32'd0);
`endif

    do_load(32'h3000, 1, -1, h, got, ra);
    chk("flush_rdata", got, 32'h0);
    do_load(32'h3004, -1, -1, h, got, ra);
    chk("flush_installed_hit", 32'(h), 32'h1);
    chk("flush_installed_rdata", got, 32'h5A5A_3004);

    do_load(32'h4000, -1, 2, h, got, ra);
    do_load(32'h4000, -1, -1, h, got, ra);
    chk("post_rst_hit", 32'(h), 32'h0);
    chk("post_rst_addr", ra, 32'h4000);
    chk("post_rst_rdata", got, 32'h5A5A_4000);

    // Flush in IDLE: a hitting load presented with flush must not be accepted
    tick(); dcache_addr = 32'h4000; dcache_rmask = 4'hF; flush = 1;
    tick(); flush = 0; dcache_rmask = 0;
    tick();
    tick();

    do_load(32'h3004, -1, -1, h, got, ra);
    chk("rst_cleared_hit", 32'(h), 32'h0);
    chk("rst_cleared_rdata", got, 32'h5A5A_3004);

`ifdef LSQ_DCACHE_PERF_EN
    chk("perf_hit_final", perf_load_hit, 32'(m_hits));
    chk("perf_miss_final", perf_load_miss, 32'(m_misses));
`else
    chk("perf_hit_final", perf_load_hit, 32'h0);
    chk("perf_miss_final", perf_load_miss, 32'h0);
`endif

    tick(); chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsq_dcache.md
Name: lsq_dcache

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits directly downstream of the load/store queue's D-cache arbiter and consumes its held request (addr, rmask, wmask, wdata).
- Returns a one-cycle `dcache_resp` pulse with word data.
- Talks to backing memory over a simple burst-read / single-write handshake.

Parameters:
- NUM_SETS, 16, number of lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush; drops the pending response
- dcache_addr  in  32  request byte address, held by the requester until resp
- dcache_rmask  in  4  load byte mask; nonzero = load request
- dcache_wmask  in  4  store byte mask; nonzero = store request
- dcache_wdata  in  32  store data, aligned to the word
- dcache_rdata  out  32  full aligned word, valid with dcache_resp for loads
- dcache_resp  out  1  one-cycle completion pulse
- mem_addr  out  32  line address (reads) or word address (writes)
- mem_read  out  1  line read request, held until mem_ready
- mem_write  out  1  word write request, held until mem_ready
- mem_wdata  out  32  write data
- mem_wmask  out  4  write byte mask
- mem_ready  in  1  memory accepts the current request
- mem_rdata  in  32  refill beat data
- mem_rvalid  in  1  refill beat valid; beats arrive in order, word 0 first
- perf_load_hit  out  32  load hit count (optional feature)
- perf_load_miss  out  32  load miss count (optional feature)

Behaviour:
- Address fields:
  - byte offset [1:0]
  - word sel [2+WB-1:2], WB = log2(LINE_WORDS)
  - index: next log2(NUM_SETS) bits
  - tag: remaining upper bits
- Storage per set: valid bit, tag, LINE_WORDS data words.
- Request valid = |rmask | |wmask. rmask and wmask are never both nonzero.
- IDLE:
  - A valid request with flush=0 latches addr/masks/wdata into internal regs; go to LOOKUP.
  - Inputs are ignored in every other state.
- LOOKUP (tag compare on the latched request):
  - Load hit: dcache_resp=1, dcache_rdata = selected word; go to IDLE.
  - Load miss: go to REFILL_REQ.
  - Store: on hit, merge wdata into the line by byte mask; on miss, leave the line untouched. Go to WRITE_REQ.
- REFILL_REQ:
  - mem_read=1, mem_addr = line-aligned address.
  - On mem_ready, go to REFILL_DATA with beat counter = 0.
- REFILL_DATA:
  - Each mem_rvalid writes the beat into line[counter], counter += 1.
  - On the last beat, set valid and write the tag; go to RESP.
- RESP: dcache_resp=1, dcache_rdata = refilled word at word sel; go to IDLE.
- WRITE_REQ:
  - mem_write=1, mem_addr = word-aligned address, mem_wdata/mem_wmask from latched regs.
  - On mem_ready, go to WDONE.
- WDONE: dcache_resp=1; go to IDLE.
- Latencies:
  - Load hit: resp one cycle after acceptance.
  - Load miss: resp one cycle after the last refill beat.
  - Store: resp one cycle after mem_ready.
- dcache_rdata is 0 whenever dcache_resp=0.
- mem_* outputs are 0 outside their own states.
- Flush:
  - Asserted in any non-IDLE state: set a drop flag. The next resp pulse is suppressed (rdata stays 0) and the flag clears on return to IDLE.
  - The refill still installs the line.
  - A store write still completes to memory, because stores reach this block only after commit.
  - Flush in IDLE: no request is accepted that cycle.
- mem_rvalid never arrives outside REFILL_DATA. The beat counter wraps to 0 after the last beat.
- Reset (asynchronous, any state):
  - State goes to IDLE, all valid bits clear, drop flag clears, counters zero.
  - All outputs are 0.
  - Any outstanding memory transaction is abandoned.
- Data array contents are not reset.

Optional Feature:
- Macro: LSQ_DCACHE_PERF_EN.
- Defined:
  - perf_load_hit increments on each LOOKUP load hit.
  - perf_load_miss increments on each LOOKUP load miss.
  - Both are 32-bit, wrap, reset to 0, and count even when the drop flag is set.
- Undefined: both ports are tied to 0 and no counter registers exist.

Test Plan:
- Cold load 0x0000_1004, rmask 1111; memory line 0x1000 = {0x11,0x22,0x33,0x44} -> mem_read with mem_addr 0x0000_1000; 4 beats; resp with rdata 0x0000_0022 one cycle after beat 4. Then load 0x1008 -> resp 0x0000_0033 one cycle after acceptance, no mem_read.
- After the above, store 0x1004 wmask 0011 wdata 0xAAAA_BBBB -> mem_write addr 0x1004 mask 0011; resp one cycle after mem_ready. Then load 0x1004 hits with 0x0000_BBBB.
- Store miss 0x2000 wmask 1111 wdata 0x5 -> mem_write only, no mem_read. Following load 0x2000 misses (mem_read addr 0x2000).
- Defaults (index bits [7:4]): load 0x1000, then 0x1100 (same index, evicts), then 0x1000 -> third access misses again. Perf build: hit=0, miss=3.
- Flush pulse during REFILL_DATA of load 0x3000 -> no dcache_resp. Subsequent load 0x3004 hits, resp one cycle after acceptance.
- rst asserted mid REFILL_DATA (beat 2) -> all outputs 0 immediately. Next load of the same line misses and issues mem_read.
